// File: rtl/cplx_pkg.sv
// cplx_pkg: shared FSM state type, default part width and field-position helpers
// for packed complex words {real, imaginary}.
package cplx_pkg;
    localparam int PART_LEN_DEF = 8;
    typedef enum logic {ACC = 1'b0, OUT = 1'b1} state_t;
    function automatic int re_msb(int pl); return 2*pl - 1; endfunction
    function automatic int re_lsb(int pl); return pl;       endfunction
    function automatic int im_msb(int pl); return pl - 1;   endfunction
    function automatic int im_lsb(int pl); return 0;        endfunction
endpackage

// File: rtl/cplx_sat_addsub.sv
// cplx_sat_addsub: signed add/subtract of one complex part, clamped to W bits.
module cplx_sat_addsub
    import cplx_pkg::*;
#(
    parameter int W = PART_LEN_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         asn,
    output logic [W-1:0] sum,
    output logic         sat
);
    logic [W:0] full;
    always_comb begin
        full = asn ? {a[W-1], a} + {b[W-1], b} : {a[W-1], a} - {b[W-1], b};
        sat  = full[W] ^ full[W-1];
        // overflow direction follows the true (W+1-bit) sign
        sum  = sat ? {full[W], {(W-1){~full[W]}}} : full[W-1:0];
    end
endmodule

// File: rtl/cplx_acc.sv
// cplx_acc: saturating complex accumulator emitting one result per BURST accepted
// samples, with valid/ready handshakes on both sides.
module cplx_acc
    import cplx_pkg::*;
#(
    parameter int PART_LEN = PART_LEN_DEF,
    parameter int BURST    = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_asn,
    input  logic [2*PART_LEN-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*PART_LEN-1:0] out_data,
    output logic                  out_sat
);
    state_t              state;
    logic [15:0]         cnt;
    logic [PART_LEN-1:0] acc_re, acc_im, sum_re, sum_im;
    logic                sat_f, sat_re, sat_im, xfer, last;

    assign in_ready  = (state == ACC);
    assign out_valid = (state == OUT);
    assign xfer      = in_valid && in_ready;
    assign last      = (cnt == 16'(BURST - 1));

    cplx_sat_addsub #(.W(PART_LEN)) u_re (
        .a(acc_re), .b(in_data[re_msb(PART_LEN):re_lsb(PART_LEN)]),
        .asn(in_asn), .sum(sum_re), .sat(sat_re)
    );
    cplx_sat_addsub #(.W(PART_LEN)) u_im (
        .a(acc_im), .b(in_data[im_msb(PART_LEN):im_lsb(PART_LEN)]),
        .asn(in_asn), .sum(sum_im), .sat(sat_im)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn || clear) begin
            state    <= ACC;
            cnt      <= '0;
            acc_re   <= '0;
            acc_im   <= '0;
            sat_f    <= 1'b0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (xfer && last) begin
            state    <= OUT;
            cnt      <= '0;
            acc_re   <= '0;
            acc_im   <= '0;
            sat_f    <= 1'b0;
            out_data <= {sum_re, sum_im};
            out_sat  <= sat_f | sat_re | sat_im;
        end else if (xfer) begin
            cnt      <= cnt + 16'd1;
            acc_re   <= sum_re;
            acc_im   <= sum_im;
            sat_f    <= sat_f | sat_re | sat_im;
        end else if (out_valid && out_ready) begin
            state    <= ACC;
        end
    end
endmodule

// File: tb/tb_cplx_acc.sv
// tb_cplx_acc: directed vectors with hand-computed results for cplx_acc (PART_LEN=8, BURST=4).
module tb_cplx_acc;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_asn = 1'b1;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_sat;
    int          n_chk = 0;
    int          n_pass = 0;

    cplx_acc #(.PART_LEN(8), .BURST(4)) dut (
        .clk(clk), .rstn(rstn), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_asn(in_asn), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic send(input logic asn, input int re, input int im);
        in_valid = 1'b1;
        in_asn   = asn;
        in_data  = {8'(re), 8'(im)};
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send4(input logic asn, input int re, input int im);
        for (int i = 0; i < 4; i++) send(asn, re, im);
    endtask

    task automatic expect_res(input string tag, input logic [15:0] data, input logic sat);
        chk({tag, "_valid"}, 16'(out_valid), 16'd1);
        chk({tag, "_ready"}, 16'(in_ready), 16'd0);
        chk({tag, "_data"}, out_data, data);
        chk({tag, "_sat"}, 16'(out_sat), 16'(sat));
        @(posedge clk);
        #1 chk({tag, "_back"}, 16'(in_ready), 16'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 16'(in_ready), 16'd1);
        chk({tag, "_valid"}, 16'(out_valid), 16'd0);
        chk({tag, "_data"}, out_data, 16'h0000);
        chk({tag, "_sat"}, 16'(out_sat), 16'd0);
    endtask

    initial begin
        #1 chk_idle("reset");
        @(negedge clk) rstn = 1'b1;
        @(negedge clk);

        send(1, 3, 5); send(1, 1, -2); send(1, 10, 0); send(1, -4, 4);
        expect_res("add", 16'h0A07, 1'b0);

        send4(0, 1, 1);
        expect_res("sub", 16'hFCFC, 1'b0);
        send(1, 5, 5); send(0, 2, 7); send(1, 0, 1); send(0, 1, 0);
        expect_res("mixed", 16'h02FF, 1'b0);

        send(1, 100, -100); send(1, 100, -100); send(1, 0, 0); send(1, 0, 0);
        expect_res("satur", 16'h7F80, 1'b1);
        send4(1, 1, 2);
        expect_res("clean", 16'h0408, 1'b0);

        out_ready = 1'b0;
        send4(1, 2, 3);
        in_valid = 1'b1;
        in_data  = 16'h0909;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 chk("bp_ready", 16'(in_ready), 16'd0);
            chk("bp_data", out_data, 16'h080C);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        expect_res("bp_rel", 16'h080C, 1'b0);
        send4(1, 1, 1);
        expect_res("bp_next", 16'h0404, 1'b0);

        send(1, 5, 5); send(1, 5, 5);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h0707;
        @(posedge clk);
        #1 clear = 1'b0;
        in_valid = 1'b0;
        chk_idle("clr_acc");
        send4(1, 1, 0);
        expect_res("clr_next", 16'h0400, 1'b0);
        send4(1, 1, 1);
        chk("clr_out_pre", 16'(out_valid), 16'd1);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        chk_idle("clr_out");

        send(1, 9, 9); send(1, 9, 9);
        #2 rstn = 1'b0;
        #1 chk_idle("rst_mid");
        @(negedge clk) rstn = 1'b1;
        out_ready = 1'b0;
        send4(1, 3, 3);
        chk("rst_out_pre", out_data, 16'h0C0C);
        #2 rstn = 1'b0;
        #1 chk_idle("rst_out");
        @(negedge clk) rstn = 1'b1;
        out_ready = 1'b1;
        send4(1, -1, 1);
        expect_res("rst_next", 16'hFC04, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
